fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//  Parametrised synchronous FIFO, next generation of the team's basic push/pop FIFO.
//  Adds first-word-fall-through (FWFT) read data, an occupancy count, and
//  programmable almost-full/almost-empty flags. Also adds sticky overflow/underflow
//  error flags and a synchronous flush. Sits between APB-side producers and
//  peripheral consumers as the standard elastic buffer.
// PARAMETERS
//  DATA_W     16        width of each entry in bits (>=1)
//  DEPTH      8         number of entries (>=2; power of two not required)
//  AF_THRESH  DEPTH-2   almost_full_o asserts when count_o >= AF_THRESH
//  AE_THRESH  2         almost_empty_o asserts when count_o <= AE_THRESH
// PORTS
//  clk             in   1                rising-edge clock
//  reset           in   1                synchronous, active-high reset
//  push_i          in   1                write request
//  push_data_i     in   DATA_W           write data, sampled with push_i
//  pop_i           in   1                read request; consumes head entry
//  pop_data_o      out  DATA_W           head entry (FWFT), valid when !empty_o
//  flush_i         in   1                synchronous discard of all contents
//  err_clr_i       in   1                clears overflow_o/underflow_o
//  count_o         out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
//  full_o          out  1                count_o == DEPTH
//  empty_o         out  1                count_o == 0
//  almost_full_o   out  1                count_o >= AF_THRESH
//  almost_empty_o  out  1                count_o <= AE_THRESH
//  overflow_o      out  1                sticky: push rejected because full
//  underflow_o     out  1                sticky: pop issued while empty
// BEHAVIOUR
//  - Reset values: rd/wr pointers 0, count_o 0, empty_o 1, full_o 0,
//    almost_empty_o 1, almost_full_o 0 (if AF_THRESH>0), overflow_o 0,
//    underflow_o 0. Storage array is not reset. pop_data_o is don't-care while empty.
//  - Reset mid-operation discards all contents. Reset overrides flush_i, push_i and pop_i.
//  - All flags and count_o are registered, or derived only from registered count.
//    They update on the clock edge after the accepting cycle.
//  - FWFT: pop_data_o = mem[rd_ptr] combinationally. The first pushed word is visible
//    the cycle after push. A pop advances to the next word in the next cycle.
//  - Pointers wrap from DEPTH-1 to 0. No power-of-two assumption.
//  - Push accepted if !full_o, or if full_o && pop_i (a slot is freed in the same cycle).
//  - Pop accepted if !empty_o. A pop while empty is ignored, sets underflow_o,
//    and does not block a simultaneous push.
//  - Push and pop both accepted: count unchanged, both pointers advance.
//  - Push while full with no pop: data dropped, count unchanged, overflow_o set.
//  - flush_i has priority over push_i/pop_i in the same cycle.
//    Next cycle: pointers 0, count 0, empty_o 1. Error flags are not cleared by flush.
//  - err_clr_i clears both sticky flags. If a new error occurs in the same cycle, set wins.
//  - The count_o width rule holds (e.g. DEPTH=8 gives 4 bits). There is no arithmetic
//    overflow of count.
// TESTING  (DATA_W=16, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
//  1. Reset, push 0x0001..0x0008 over 8 cycles -> full_o=1, count_o=8,
//     almost_full_o from count 6, pop_data_o=0x0001.
//  2. From full, push 0xDEAD without pop -> overflow_o=1, count_o=8.
//     Then pop 8 times -> data 0x0001..0x0008 in order, empty_o=1.
//  3. Pop while empty -> underflow_o=1, count_o=0.
//     Then err_clr_i for 1 cycle -> both error flags 0.
//  4. Full FIFO, push 0x00AA + pop same cycle -> count_o stays 8, no overflow.
//     Output order ends ...0x0008, 0x00AA (checks wrap of both pointers).
//  5. Count 5, assert flush_i + push_i -> next cycle count_o=0, empty_o=1.
//     Next push 0x1234 appears on pop_data_o the following cycle.
//  6. Empty, push 0x5555 + pop same cycle -> push accepted, underflow_o=1,
//     count_o=1, pop_data_o=0x5555. Then reset mid-fill -> all outputs at reset values.

Source files
------------

// File: rtl/fifo_flex_if.sv
// Handshake and status bundle between a producer/consumer and fifo_flex.
// The master drives requests and data; the slave (the FIFO) returns data and status.
interface fifo_flex_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              flush_i;
  logic              err_clr_i;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output push_i, push_data_i, pop_i, flush_i, err_clr_i,
    input  pop_data_o, count_o, full_o, empty_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, push_data_i, pop_i, flush_i, err_clr_i,
    output pop_data_o, count_o, full_o, empty_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_flex.sv
// Synchronous first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow and flush.
module fifo_flex #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_flex_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic full, empty;
  logic push_ok, pop_ok, mem_we;

  // Status flags derive only from the registered count, so they never glitch.
  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_we      = 1'b0;
    push_ok     = bus.push_i && (!full || bus.pop_i);
    pop_ok      = bus.pop_i && !empty;
    overflow_d  = overflow_q && !bus.err_clr_i;
    underflow_d = underflow_q && !bus.err_clr_i;

    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
      // A new error in the same cycle as err_clr_i wins over the clear.
      if (bus.push_i && full && !bus.pop_i) overflow_d = 1'b1;
      if (bus.pop_i && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[wr_ptr_q] <= bus.push_data_i;
  end

  assign bus.pop_data_o     = mem_q[rd_ptr_q];
  assign bus.count_o        = count_q;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (int'(count_q) >= AF_THRESH);
  assign bus.almost_empty_o = (int'(count_q) <= AE_THRESH);
  assign bus.overflow_o     = overflow_q;
  assign bus.underflow_o    = underflow_q;
endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: table-driven status vectors, hand-written
// corner sequences, and a queue scoreboard for read-data ordering.
module tb_fifo_flex;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_flex_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_flex #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    bit          push;
    logic [15:0] data;
    bit          pop;
    bit          clr;
    int          cnt;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] model_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string name, input int cnt, input bit ovf, input bit unf);
    check({name, ".count"},        int'(bus.count_o),        cnt);
    check({name, ".full"},         int'(bus.full_o),         int'(cnt == DEPTH));
    check({name, ".empty"},        int'(bus.empty_o),        int'(cnt == 0));
    check({name, ".almost_full"},  int'(bus.almost_full_o),  int'(cnt >= AF));
    check({name, ".almost_empty"}, int'(bus.almost_empty_o), int'(cnt <= AE));
    check({name, ".overflow"},     int'(bus.overflow_o),     int'(ovf));
    check({name, ".underflow"},    int'(bus.underflow_o),    int'(unf));
  endtask

  // Drive one cycle; the scoreboard checks popped data and tracks accepted pushes.
  task automatic step(input bit push, input logic [15:0] data, input bit pop,
                      input bit flush, input bit clr);
    bit          m_full;
    bit          m_empty;
    logic [15:0] exp_data;
    bus.push_i      = push;
    bus.push_data_i = data;
    bus.pop_i       = pop;
    bus.flush_i     = flush;
    bus.err_clr_i   = clr;
    m_full  = (model_q.size() == DEPTH);
    m_empty = (model_q.size() == 0);
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop && !m_empty) begin
        exp_data = model_q.pop_front();
        check("pop_data", int'(bus.pop_data_o), int'(exp_data));
      end
      if (push && (!m_full || pop)) model_q.push_back(data);
    end
    @(posedge clk);
    #1;
    bus.push_i    = 1'b0;
    bus.pop_i     = 1'b0;
    bus.flush_i   = 1'b0;
    bus.err_clr_i = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input bit push, input logic [15:0] d,
                              input bit pop, input bit clr, input int cnt,
                              input bit ovf, input bit unf);
    vec_t v;
    v.name = n; v.push = push; v.data = d; v.pop = pop; v.clr = clr;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  initial begin
    reset           = 1'b1;
    bus.push_i      = 1'b0;
    bus.push_data_i = '0;
    bus.pop_i       = 1'b0;
    bus.flush_i     = 1'b0;
    bus.err_clr_i   = 1'b0;

    // Fill to full, overflow, drain in order, underflow, clear, set-beats-clear.
    for (int k = 1; k <= 8; k++) vecs.push_back(mk("t1_push", 1, 16'(k), 0, 0, k, 0, 0));
    vecs.push_back(mk("t2_overflow", 1, 16'hDEAD, 0, 0, 8, 1, 0));
    for (int k = 7; k >= 0; k--) vecs.push_back(mk("t2_pop", 0, '0, 1, 0, k, 1, 0));
    vecs.push_back(mk("t3_underflow", 0, '0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("t3_clear", 0, '0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t3_set_wins", 0, '0, 1, 1, 0, 0, 1));
    vecs.push_back(mk("t3_clear2", 0, '0, 0, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("reset", 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].data, vecs[i].pop, 1'b0, vecs[i].clr);
      check_outputs(vecs[i].name, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
      if (i == 7) check("t1_head", int'(bus.pop_data_o), 16'h0001);
    end

    // Push and pop together while full: both pointers wrap, order preserved.
    for (int k = 1; k <= 8; k++) step(1, 16'(k), 0, 0, 0);
    check_outputs("t4_fill", 8, 0, 0);
    step(1, 16'h00AA, 1, 0, 0);
    check_outputs("t4_pushpop", 8, 0, 0);
    repeat (8) step(0, '0, 1, 0, 0);
    check_outputs("t4_drain", 0, 0, 0);

    // Flush beats a simultaneous push; the next push falls through.
    for (int k = 0; k < 5; k++) step(1, 16'h0010 + 16'(k), 0, 0, 0);
    check_outputs("t5_count5", 5, 0, 0);
    step(1, 16'h9999, 0, 1, 0);
    check_outputs("t5_flush", 0, 0, 0);
    step(1, 16'h1234, 0, 0, 0);
    check("t5_head", int'(bus.pop_data_o), 16'h1234);
    check_outputs("t5_after", 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // Pop while empty does not block a same-cycle push.
    step(1, 16'h5555, 1, 0, 0);
    check_outputs("t6_pushpop_empty", 1, 0, 1);
    check("t6_head", int'(bus.pop_data_o), 16'h5555);
    step(1, 16'h6666, 0, 0, 0);
    step(1, 16'h7777, 0, 0, 0);
    check_outputs("t6_fill", 3, 0, 1);

    // Reset mid-fill overrides a simultaneous push.
    reset           = 1'b1;
    bus.push_i      = 1'b1;
    bus.push_data_i = 16'hBAD0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.push_i = 1'b0;
    model_q.delete();
    check_outputs("t6_reset", 0, 0, 0);
    step(1, 16'h0BEE, 0, 0, 0);
    check("t6_post_reset_head", int'(bus.pop_data_o), 16'h0BEE);
    check_outputs("t6_post_reset", 1, 0, 0);
    step(0, '0, 1, 0, 0);
    check_outputs("t6_final", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
